// File: rtl/bufz_bus_arbiter.sv
// -----------------------------------------------------------------------------
// bufz_bus_arbiter
//
// Round-robin arbiter and sequencer for a shared tri-state bus. Each requester
// drives the bus through its own bufz cell; this block produces the one-hot EN
// vector for those cells. Ownership changes are break-before-make: every change
// of owner passes through TA_CYCLES cycles with all enables low. While other
// requesters are waiting, an owner's tenure is capped at MAX_HOLD cycles.
//
// Handshake: req[i] is a level request. gnt[i] high means requester i owns the
// bus this cycle and may drive its data. A gnt fall while req[i] is still high
// is a preemption. Dropping req[i] while not granted simply withdraws it.
//
// Ports
//   CLK        in   1                 clock, rising edge
//   RN         in   1                 asynchronous active-low reset
//   bus_on     in   1                 global enable; low blocks new grants and
//                                     releases the current owner
//   req        in   N_REQ             per-requester bus request (level)
//   gnt        out  N_REQ             grant, one-hot or zero, registered
//   en         out  N_REQ             bufz EN vector, same value as gnt,
//                                     from its own flops
//   owner      out  $clog2(N_REQ)     index of the current / last owner
//   busy       out  1                 high while in DRIVE or TURN
//   state_dbg  out  2                 FSM state (0 IDLE, 1 DRIVE, 2 TURN)
// -----------------------------------------------------------------------------
module bufz_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TA_CYCLES = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic                       CLK,
    input  logic                       RN,
    input  logic                       bus_on,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           en,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int OW = $clog2(N_REQ);
    // Candidate index width: rr_ptr + offset can reach 2*N_REQ-2 before wrap.
    localparam int CW = OW + 1;
    // Hold counter must be able to hold MAX_HOLD; keep at least one bit.
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [CW-1:0] N_REQ_C  = CW'(N_REQ);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    // With MAX_HOLD==0 the cap is never used; the counter just stops at all-ones.
    localparam logic [HW-1:0] HOLD_SAT = HW'((MAX_HOLD == 0) ? ((1 << HW) - 1) : MAX_HOLD);
    localparam logic [3:0]    TA_LAST  = 4'(TA_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [N_REQ-1:0]  en_q;
    logic [OW-1:0]     owner_q,    owner_d;
    logic [OW-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [3:0]        ta_cnt_q,   ta_cnt_d;
    logic              busy_q,     busy_d;

    // Round-robin pick: first set req at or after rr_ptr, wrapping to 0.
    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     pick_next;
    logic [CW-1:0]     cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= N_REQ_C) begin
                cand = cand - N_REQ_C;
            end
            if (!pick_found && req[cand[OW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[OW-1:0];
            end
        end
        pick_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    end

    // Release decision for the current owner. In DRIVE gnt_q is exactly the
    // owner's one-hot, so it doubles as the owner mask.
    logic own_req;
    logic other_req;
    logic hold_expired;
    logic release_now;
    logic grant_now;

    always_comb begin
        own_req      = |(req & gnt_q);
        other_req    = |(req & ~gnt_q);
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX) && other_req;
        release_now  = !own_req || !bus_on || hold_expired;
        grant_now    = bus_on && pick_found;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        ta_cnt_d   = ta_cnt_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (grant_now) begin
                    state_d    = DRIVE;
                    gnt_d      = N_REQ'(1) << pick_idx;
                    owner_d    = pick_idx;
                    rr_ptr_d   = pick_next;
                    hold_cnt_d = HW'(1);
                end
            end

            DRIVE: begin
                if (release_now) begin
                    // Break first: enables go low, turnaround starts.
                    state_d  = TURN;
                    gnt_d    = '0;
                    ta_cnt_d = 4'd1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            TURN: begin
                gnt_d = '0;
                if (ta_cnt_q >= TA_LAST) begin
                    // Last all-off cycle: arbitrate exactly as from IDLE.
                    if (grant_now) begin
                        state_d    = DRIVE;
                        gnt_d      = N_REQ'(1) << pick_idx;
                        owner_d    = pick_idx;
                        rr_ptr_d   = pick_next;
                        hold_cnt_d = HW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ta_cnt_d = ta_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // en gets its own flops fed from the same next value as gnt, so the bufz
    // enables are direct flop outputs with no decode glitches, and the async
    // reset drops them immediately.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            en_q       <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            ta_cnt_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            en_q       <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            ta_cnt_q   <= ta_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign en        = en_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bufz_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bufz_bus_arbiter
//
// Scoreboard bench. A reference model advances once per rising edge from the
// sampled req/bus_on and pushes the expected {en, owner, busy} into exp_q.
// A monitor on the falling edge pops and compares, and also checks en==gnt,
// en one-hot-or-zero and the all-off gap between different owners.
// Handshake: inputs change 2 time units after a rising edge; outputs are read
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_bufz_bus_arbiter;

  localparam int N  = 4;
  localparam int TA = 1;
  localparam int MH = 4;
  localparam int W  = 7;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rn;
  logic         bus_on;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] en;
  logic [1:0]   owner;
  logic         busy;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  bufz_bus_arbiter #(
    .N_REQ    (N),
    .TA_CYCLES(TA),
    .MAX_HOLD (MH)
  ) dut (
    .CLK      (clk),
    .RN       (rn),
    .bus_on   (bus_on),
    .req      (req),
    .gnt      (gnt),
    .en       (en),
    .owner    (owner),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int grant_log[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bus described as: an active owner with a tenure length, or a quiet stretch
  // counted in cycles since the last owner let go.
  bit m_active;
  int m_own;
  int m_tenure;
  int m_quiet;
  int m_ptr;

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_own    = 0;
    m_tenure = 0;
    m_quiet  = 0;
    m_ptr    = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic b);
    int k;
    if (m_active) begin
      logic [N-1:0] others;
      others = r & ~(N'(1) << m_own);
      if (!r[m_own] || !b || (MH > 0 && m_tenure >= MH && others != 0)) begin
        m_active = 0;
        m_quiet  = 1;
      end else begin
        m_tenure++;
      end
    end else if (m_quiet > 0 && m_quiet < TA) begin
      m_quiet++;
    end else begin
      k = rr_pick(r, m_ptr);
      if (b && k >= 0) begin
        m_active = 1;
        m_own    = k;
        m_tenure = 1;
        m_ptr    = (k + 1) % N;
      end
      m_quiet = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rn);
      if (!rn) begin
        model_reset();
        exp_q.delete();
      end else begin
        logic [N-1:0] e_en;
        logic [1:0]   e_own;
        model_edge(req, bus_on);
        e_en  = m_active ? (N'(1) << m_own) : '0;
        e_own = m_own[1:0];
        exp_q.push_back({e_en, e_own, (m_active || m_quiet > 0)});
      end
    end
  end

  // ---------------- monitor ----------------
  int           last_own = -1;
  int           zeros    = 0;
  logic [N-1:0] prev_en  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rn) begin
        last_own = -1;
        zeros    = 0;
        prev_en  = '0;
      end else begin
        if (exp_q.size() > 0) begin
          logic [W-1:0] want;
          want = exp_q.pop_front();
          check("sb_en_owner_busy", {en, owner, busy}, want);
        end
        check("en_eq_gnt", en, gnt);
        check("en_onehot0", $onehot0(en), 1);
        if (en == 0) begin
          zeros++;
        end else begin
          int k;
          k = $clog2(en);
          if (last_own >= 0 && k != last_own) check("ta_gap_ok", zeros >= TA, 1);
          if (prev_en == 0) grant_log.push_back(k);
          last_own = k;
          zeros    = 0;
        end
        prev_en = en;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rn = 1'b0;
    step(1);
    rn = 1'b1;
  endtask

  initial begin
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    rn     = 1'b0;
    req    = '0;
    bus_on = 1'b0;

    // Reset values while held in reset.
    step(3);
    check("rst_en", en, 0);
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rn = 1'b1;

    // Async reset drops en without an edge.
    req    = 4'b0100;
    bus_on = 1'b1;
    step(3);
    check("pre_async_en", en, 4'b0100);
    #1 rn = 1'b0;
    #1;
    check("async_en", en, 0);
    check("async_gnt", gnt, 0);
    check("async_busy", busy, 0);
    step(1);
    rn  = 1'b1;
    req = '0;
    check("post_rst_state", state_dbg, 0);
    check("post_rst_owner", owner, 0);

    // Single request, then drop.
    step(2);
    req = 4'b0010;
    step(5);
    req = '0;
    step(4);
    check("single_idle_busy", busy, 0);
    check("single_owner_held", owner, 1);

    // Round robin with all requesting.
    pulse_reset();
    grant_log.delete();
    req = 4'b1111;
    step(22);
    check("rr_grant_count", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("rr_seq", grant_log[i], exp_seq[i]);
    end
    req = '0;
    step(4);

    // No contention: single owner keeps the bus past MAX_HOLD.
    req = 4'b0001;
    step(40);
    check("solo_en", en, 4'b0001);
    req = '0;
    step(3);

    // bus_on low mid-DRIVE.
    req = 4'b0001;
    step(3);
    bus_on = 1'b0;
    step(5);
    check("bus_off_en", en, 0);
    check("bus_off_busy", busy, 0);
    bus_on = 1'b1;
    step(2);
    check("bus_on_regrant", en, 4'b0001);
    req = '0;
    step(3);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      bus_on = ($urandom_range(0, 9) != 0);
      step(1);
    end
    req    = '0;
    bus_on = 1'b1;
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
